// File: rtl/battle_ctl.sv
`default_nettype none
// ============================================================================
// Module  : battle_ctl
// Brief   : Ship-battle game sequencer: mouse click to board cell mapping,
//           placement, turn-taking and shot handshake, advanced on frame_start.
//           Optional macro BATTLE_CTL_REPEAT_ON_HIT_EN keeps the turn after a hit.
// Revision: 1.0  initial release
// ============================================================================
module battle_ctl #(
  parameter int BOARD_N    = 10,
  parameter int CELL_LOG2  = 5,
  parameter int X0         = 608,
  parameter int Y0         = 193,
  parameter int SHIPS      = 10,
  parameter int SHIP_CELLS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        mouse_left,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  input  logic        first_player,
  input  logic        shot_ack,
  input  logic        shot_hit,
  input  logic        opp_miss,
  input  logic        opp_won,
  output logic [7:0]  cell_pos,
  output logic        place_req,
  output logic        shot_req,
  output logic [3:0]  ships_placed,
  output logic [4:0]  hits_left,
  output logic [2:0]  state_o,
  output logic        game_over,
  output logic        win
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLACE = 3'd1,
    S_WAIT  = 3'd2,
    S_AIM   = 3'd3,
    S_FIRE  = 3'd4,
    S_OVER  = 3'd5
  } state_t;

  localparam logic [12:0] c_x_lo       = 13'(X0);
  localparam logic [12:0] c_x_hi       = 13'(X0 + (BOARD_N << CELL_LOG2));
  localparam logic [12:0] c_y_lo       = 13'(Y0);
  localparam logic [12:0] c_y_hi       = 13'(Y0 + (BOARD_N << CELL_LOG2));
  localparam logic [3:0]  c_ships      = 4'(SHIPS);
  localparam logic [4:0]  c_ship_cells = 5'(SHIP_CELLS);
`ifdef BATTLE_CTL_REPEAT_ON_HIT_EN
  localparam state_t c_after_hit = S_AIM;
`else
  localparam state_t c_after_hit = S_WAIT;
`endif

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_cell, w_cell_nxt;
  logic        r_place, w_place_nxt;
  logic        r_shot, w_shot_nxt;
  logic [3:0]  r_placed, w_placed_nxt;
  logic [4:0]  r_hits, w_hits_nxt, w_hits_dec;
  logic        r_over, w_over_nxt;
  logic        r_win, w_win_nxt;

  logic        r_ml_q, r_ml_qq;
  logic        r_click_pend;
  logic [7:0]  r_click_cell;
  logic        r_ack, r_hit, r_miss, r_won;
  logic        w_ack, w_hit, w_miss, w_won;
  logic [11:0] w_dx, w_dy;
  logic [3:0]  w_col, w_row;
  logic        w_in_board, w_rise;

  assign w_dx       = mouse_xpos - c_x_lo[11:0];
  assign w_dy       = mouse_ypos - c_y_lo[11:0];
  assign w_col      = 4'(w_dx >> CELL_LOG2);
  assign w_row      = 4'(w_dy >> CELL_LOG2);
  assign w_in_board = ({1'b0, mouse_xpos} >= c_x_lo) && ({1'b0, mouse_xpos} < c_x_hi) &&
                      ({1'b0, mouse_ypos} >= c_y_lo) && ({1'b0, mouse_ypos} < c_y_hi);
  assign w_rise     = r_ml_q & ~r_ml_qq;

  // Off-board clicks never become pending, so an earlier valid click survives them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ml_q       <= 1'b0;
      r_ml_qq      <= 1'b0;
      r_click_pend <= 1'b0;
      r_click_cell <= 8'd0;
    end else begin
      r_ml_q  <= mouse_left;
      r_ml_qq <= r_ml_q;
      if (w_rise && w_in_board) begin
        r_click_pend <= 1'b1;
        r_click_cell <= {w_row, w_col};
      end else if (frame_start) begin
        r_click_pend <= 1'b0;
      end
    end
  end

  // Sticky event flags; every frame_start consumes them whether used or not.
  always_ff @(posedge clk) begin
    if (rst || frame_start) begin
      r_ack  <= 1'b0;
      r_hit  <= 1'b0;
      r_miss <= 1'b0;
      r_won  <= 1'b0;
    end else begin
      if (shot_ack) begin
        r_ack <= 1'b1;
        r_hit <= shot_hit;
      end
      if (opp_miss) r_miss <= 1'b1;
      if (opp_won)  r_won  <= 1'b1;
    end
  end

  assign w_ack      = r_ack | shot_ack;
  assign w_hit      = shot_ack ? shot_hit : r_hit;
  assign w_miss     = r_miss | opp_miss;
  assign w_won      = r_won | opp_won;
  assign w_hits_dec = (r_hits == 5'd0) ? 5'd0 : r_hits - 5'd1;

  always_comb begin
    w_state_nxt  = r_state;
    w_cell_nxt   = r_cell;
    w_place_nxt  = 1'b0;
    w_shot_nxt   = r_shot;
    w_placed_nxt = r_placed;
    w_hits_nxt   = r_hits;
    w_over_nxt   = r_over;
    w_win_nxt    = r_win;
    if (frame_start) begin
      if (w_won && (r_state == S_WAIT || r_state == S_AIM || r_state == S_FIRE)) begin
        w_state_nxt = S_OVER;
        w_shot_nxt  = 1'b0;
        w_over_nxt  = 1'b1;
        w_win_nxt   = 1'b0;
      end else begin
        case (r_state)
          S_IDLE: if (r_click_pend) w_state_nxt = S_PLACE;
          S_PLACE: begin
            if (r_click_pend && r_placed < c_ships) begin
              w_cell_nxt   = r_click_cell;
              w_place_nxt  = 1'b1;
              w_placed_nxt = r_placed + 4'd1;
              if (w_placed_nxt == c_ships) w_state_nxt = first_player ? S_AIM : S_WAIT;
            end
          end
          S_WAIT: if (w_miss) w_state_nxt = S_AIM;
          S_AIM: begin
            if (r_click_pend) begin
              w_cell_nxt  = r_click_cell;
              w_shot_nxt  = 1'b1;
              w_state_nxt = S_FIRE;
            end
          end
          S_FIRE: begin
            if (w_ack) begin
              w_shot_nxt = 1'b0;
              if (w_hit) begin
                w_hits_nxt = w_hits_dec;
                if (w_hits_dec == 5'd0) begin
                  w_state_nxt = S_OVER;
                  w_over_nxt  = 1'b1;
                  w_win_nxt   = 1'b1;
                end else begin
                  w_state_nxt = c_after_hit;
                end
              end else begin
                w_state_nxt = S_WAIT;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cell   <= 8'd0;
      r_place  <= 1'b0;
      r_shot   <= 1'b0;
      r_placed <= 4'd0;
      r_hits   <= c_ship_cells;
      r_over   <= 1'b0;
      r_win    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cell   <= w_cell_nxt;
      r_place  <= w_place_nxt;
      r_shot   <= w_shot_nxt;
      r_placed <= w_placed_nxt;
      r_hits   <= w_hits_nxt;
      r_over   <= w_over_nxt;
      r_win    <= w_win_nxt;
    end
  end

  assign cell_pos     = r_cell;
  assign place_req    = r_place;
  assign shot_req     = r_shot;
  assign ships_placed = r_placed;
  assign hits_left    = r_hits;
  assign state_o      = r_state;
  assign game_over    = r_over;
  assign win          = r_win;

endmodule
`default_nettype wire
